// File: rtl/pc_fetch_unit_pkg.sv
// AlicePU fetch-stage constants: PC operation encodings, fetch FSM encodings and reset PC.
// Shared by the fetch unit and its next-PC calculator.
package pc_fetch_unit_pkg;

  localparam int PC_OP_LEN = 3;

  localparam logic [PC_OP_LEN-1:0] PC_OP_NEXT_STEP  = 3'd0;
  localparam logic [PC_OP_LEN-1:0] PC_OP_OFFSET_JMP = 3'd1;
  localparam logic [PC_OP_LEN-1:0] PC_OP_IMM_JMP    = 3'd2;
  localparam logic [PC_OP_LEN-1:0] PC_OP_REG_JMP    = 3'd3;

  localparam int FETCH_STATE_LEN = 2;

  typedef enum logic [FETCH_STATE_LEN-1:0] {
    FETCH_S_BOOT  = 2'd0,
    FETCH_S_FETCH = 2'd1,
    FETCH_S_EXEC  = 2'd2,
    FETCH_S_TRAP  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection from the current pc, committed instruction and control's pc_op.
// With PC_ALIGN_TRAP_EN the raw target and a misalignment flag are exposed; otherwise the target is word-aligned here.
module next_pc_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0]          pc,
  input  logic [PC_OP_LEN-1:0] pc_op,
  input  logic [31:0]          offset_imm,
  input  logic [25:0]          inst_idx,
  input  logic [31:0]          reg_target,
  output logic [31:0]          pc_plus4,
`ifdef PC_ALIGN_TRAP_EN
  output logic                 misaligned,
`endif
  output logic [31:0]          next_pc
);

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    case (pc_op)
      PC_OP_NEXT_STEP:  next_pc = pc_plus4;
      PC_OP_OFFSET_JMP: next_pc = pc_plus4 + (offset_imm << 2);
      PC_OP_IMM_JMP:    next_pc = {pc_plus4[31:28], inst_idx, 2'b00};
      PC_OP_REG_JMP:    next_pc = reg_target;
      default:          next_pc = pc_plus4;
    endcase
`ifndef PC_ALIGN_TRAP_EN
    // Only a register jump can produce a non-word target; silently align it.
    next_pc[1:0] = 2'b00;
`endif
  end

`ifdef PC_ALIGN_TRAP_EN
  assign misaligned = (next_pc[1:0] != 2'b00);
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// AlicePU fetch stage: owns pc, fetches over imem req/ack, holds inst until exec_done commits (min 2 cycles/instr).
// Request held until ack; optional misaligned-target trap under macro PC_ALIGN_TRAP_EN.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          COUNT_W  = 32
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_OP_LEN-1:0] pc_op,
  input  logic                 exec_done,
  input  logic [31:0]          offset_imm,
  input  logic [31:0]          reg_target,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          inst,
  output logic                 inst_valid,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic [COUNT_W-1:0]   retired_cnt
`ifdef PC_ALIGN_TRAP_EN
  ,
  output logic                 pc_trap,
  output logic [31:0]          trap_addr
`endif
);

  fetch_state_t state;
  logic [31:0]  next_pc;
`ifdef PC_ALIGN_TRAP_EN
  logic         misaligned;
`endif

  next_pc_calc u_next_pc_calc (
    .pc         (pc),
    .pc_op      (pc_op),
    .offset_imm (offset_imm),
    .inst_idx   (inst[25:0]),
    .reg_target (reg_target),
    .pc_plus4   (pc_plus4),
`ifdef PC_ALIGN_TRAP_EN
    .misaligned (misaligned),
`endif
    .next_pc    (next_pc)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH_S_BOOT;
      pc          <= RESET_PC;
      inst        <= 32'h0;
      inst_valid  <= 1'b0;
      imem_req    <= 1'b0;
      retired_cnt <= '0;
`ifdef PC_ALIGN_TRAP_EN
      pc_trap     <= 1'b0;
      trap_addr   <= 32'h0;
`endif
    end else begin
      case (state)
        FETCH_S_BOOT: begin
          state    <= FETCH_S_FETCH;
          imem_req <= 1'b1;
        end
        FETCH_S_FETCH: begin
          if (imem_ack) begin
            inst       <= imem_rdata;
            imem_req   <= 1'b0;
            inst_valid <= 1'b1;
            state      <= FETCH_S_EXEC;
          end
        end
        FETCH_S_EXEC: begin
          if (exec_done) begin
            retired_cnt <= retired_cnt + COUNT_W'(1);
            inst_valid  <= 1'b0;
`ifdef PC_ALIGN_TRAP_EN
            // The faulting instruction still retires; pc keeps its address for diagnosis.
            if (misaligned) begin
              state     <= FETCH_S_TRAP;
              pc_trap   <= 1'b1;
              trap_addr <= next_pc;
            end else
`endif
            begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= FETCH_S_FETCH;
            end
          end
        end
`ifdef PC_ALIGN_TRAP_EN
        FETCH_S_TRAP: begin
          imem_req <= 1'b0;
        end
`endif
        default: begin
          state      <= FETCH_S_BOOT;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with hand-computed pc / inst / counter expectations.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  logic                 clk;
  logic                 rst;
  logic [PC_OP_LEN-1:0] pc_op;
  logic                 exec_done;
  logic [31:0]          offset_imm;
  logic [31:0]          reg_target;
  logic                 imem_req;
  logic [31:0]          imem_addr;
  logic                 imem_ack;
  logic [31:0]          imem_rdata;
  logic [31:0]          inst;
  logic                 inst_valid;
  logic [31:0]          pc;
  logic [31:0]          pc_plus4;
  logic [31:0]          retired_cnt;
`ifdef PC_ALIGN_TRAP_EN
  logic                 pc_trap;
  logic [31:0]          trap_addr;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_3000), .COUNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_op       (pc_op),
    .exec_done   (exec_done),
    .offset_imm  (offset_imm),
    .reg_target  (reg_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retired_cnt (retired_cnt)
`ifdef PC_ALIGN_TRAP_EN
    ,
    .pc_trap     (pc_trap),
    .trap_addr   (trap_addr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the unit is requesting a fetch.
  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) return;
      tick();
    end
    chk("req_timeout", {31'b0, imem_req}, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] rdata);
    wait_req();
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    tick();
    imem_ack   = 1'b0;
  endtask

  task automatic commit(input logic [PC_OP_LEN-1:0] op, input logic [31:0] off,
                        input logic [31:0] tgt);
    pc_op      = op;
    offset_imm = off;
    reg_target = tgt;
    exec_done  = 1'b1;
    tick();
    exec_done  = 1'b0;
    pc_op      = PC_OP_NEXT_STEP;
  endtask

  task automatic step(input logic [31:0] rdata, input logic [PC_OP_LEN-1:0] op,
                      input logic [31:0] off, input logic [31:0] tgt);
    fetch(rdata);
    commit(op, off, tgt);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    pc_op      = PC_OP_NEXT_STEP;
    exec_done  = 1'b0;
    offset_imm = 32'h0;
    reg_target = 32'h0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    tick();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_pc", pc, 32'h3000);
    chk("rst_inst", inst, 32'h0);
    chk("rst_cnt", retired_cnt, 32'd0);

    // Ack during the boot cycle must be ignored.
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    rst        = 1'b0;
    tick();
    imem_ack   = 1'b0;
    chk("boot_req", {31'b0, imem_req}, 32'd1);
    chk("boot_ack_ignored", inst, 32'h0);
    chk("first_addr", imem_addr, 32'h3000);

    fetch(32'h2008_0005);
    chk("t1_inst", inst, 32'h2008_0005);
    chk("t1_valid", {31'b0, inst_valid}, 32'd1);
    chk("t1_req_low", {31'b0, imem_req}, 32'd0);
    commit(PC_OP_NEXT_STEP, 32'h0, 32'h0);
    chk("t1_pc", pc, 32'h3004);
    chk("t1_cnt", retired_cnt, 32'd1);
    chk("t1_valid_drop", {31'b0, inst_valid}, 32'd0);

    // Delayed ack with a spurious exec_done during fetch.
    for (int i = 0; i < 5; i++) begin
      chk("dly_req", {31'b0, imem_req}, 32'd1);
      chk("dly_addr", imem_addr, 32'h3004);
      if (i == 2) begin
        pc_op      = PC_OP_REG_JMP;
        reg_target = 32'h0000_1234;
        exec_done  = 1'b1;
      end
      tick();
      exec_done = 1'b0;
      pc_op     = PC_OP_NEXT_STEP;
    end
    chk("dly_req6", {31'b0, imem_req}, 32'd1);
    chk("dly_pc", pc, 32'h3004);
    chk("dly_cnt", retired_cnt, 32'd1);
    fetch(32'h1111_1111);
    imem_ack   = 1'b1;
    imem_rdata = 32'h2222_2222;
    tick();
    imem_ack   = 1'b0;
    chk("exec_ack_ignored", inst, 32'h1111_1111);
    commit(PC_OP_NEXT_STEP, 32'h0, 32'h0);
    chk("dly_pc_next", pc, 32'h3008);
    chk("dly_cnt_next", retired_cnt, 32'd2);

    step(32'h0, PC_OP_NEXT_STEP, 32'h0, 32'h0);
    step(32'h0, PC_OP_NEXT_STEP, 32'h0, 32'h0);
    chk("pc_3010", pc, 32'h3010);
    step(32'h0, PC_OP_OFFSET_JMP, 32'hFFFF_FFFE, 32'h0);
    chk("off_neg", pc, 32'h300C);
    step(32'h0, PC_OP_NEXT_STEP, 32'h0, 32'h0);
    step(32'h0, PC_OP_OFFSET_JMP, 32'h0000_0003, 32'h0);
    chk("off_pos", pc, 32'h3020);
    step(32'h0, 3'd7, 32'h0000_0100, 32'h0000_5000);
    chk("bad_op", pc, 32'h3024);
    chk("cnt_8", retired_cnt, 32'd8);

    step(32'h0, PC_OP_REG_JMP, 32'h0, 32'hFFFF_FFFC);
    chk("reg_jmp", pc, 32'hFFFF_FFFC);
    fetch(32'h0);
    chk("wrap_plus4", pc_plus4, 32'h0);
    commit(PC_OP_NEXT_STEP, 32'h0, 32'h0);
    chk("wrap_pc", pc, 32'h0);

    // Async reset in the middle of a fetch cycle.
    chk("mid_req_pre", {31'b0, imem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_req_async", {31'b0, imem_req}, 32'd0);
    chk("mid_pc", pc, 32'h3000);
    chk("mid_cnt", retired_cnt, 32'd0);
    tick();
    rst = 1'b0;
    wait_req();
    chk("mid_refetch", imem_addr, 32'h3000);

    fetch(32'h0C00_0C10);
    chk("imm_pc", pc, 32'h3000);
    chk("imm_plus4", pc_plus4, 32'h3004);
    commit(PC_OP_IMM_JMP, 32'h0, 32'h0);
    chk("imm_jmp", pc, 32'h0000_3040);

    apply_reset();
    fetch(32'h0);
    commit(PC_OP_REG_JMP, 32'h0, 32'h0000_3002);
`ifdef PC_ALIGN_TRAP_EN
    chk("trap_flag", {31'b0, pc_trap}, 32'd1);
    chk("trap_addr", trap_addr, 32'h3002);
    chk("trap_pc", pc, 32'h3000);
    chk("trap_cnt", retired_cnt, 32'd1);
    tick();
    tick();
    chk("trap_req", {31'b0, imem_req}, 32'd0);
`else
    chk("align_pc", pc, 32'h3000);
    chk("align_cnt", retired_cnt, 32'd1);
    chk("align_req", {31'b0, imem_req}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Upstream fetch stage of AlicePU. Owns the program counter and fetches each instruction from instruction memory over a req/ack handshake.
- Holds the instruction stable for decode/execute until commit, then applies the PC operation chosen by control to compute the next PC.
- Also provides pc_plus4 for the jal link write and a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- COUNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- pc_op  in  `PC_OP_LEN  next-PC select from control; sampled only on exec_done.
- exec_done  in  1  single-cycle commit pulse from execute stage.
- offset_imm  in  32  sign-extended 16-bit branch immediate.
- reg_target  in  32  rs register value for jr.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ack  in  1  fetch data valid.
- imem_rdata  in  32  fetched instruction word.
- inst  out  32  latched instruction.
- inst_valid  out  1  inst holds a fetched, uncommitted instruction.
- pc  out  32  address of current instruction.
- pc_plus4  out  32  pc+4, combinational.
- retired_cnt  out  COUNT_W  number of committed instructions.

Behaviour:
- Reset (async, rst=1):
  - state=S_BOOT, pc=RESET_PC, inst=32'h0 (nop).
  - inst_valid=0, imem_req=0, retired_cnt=0.
  - An imem_ack arriving during or right after reset is ignored unless state is S_FETCH.
- FSM states S_BOOT, S_FETCH, S_EXEC. Transitions:
  - S_BOOT: one cycle, then S_FETCH.
  - S_FETCH: imem_req=1, imem_addr=pc held stable. On imem_ack: inst<=imem_rdata, go to S_EXEC. Request held indefinitely until ack.
  - S_EXEC: imem_req=0, inst_valid=1. On exec_done: pc<=next_pc, retired_cnt+=1, inst_valid drops the next cycle, go to S_FETCH.
- Minimum latency is 1 cycle fetch plus 1 cycle execute per instruction when ack and exec_done arrive as early as possible.
- Ignored events:
  - imem_ack outside S_FETCH.
  - exec_done outside S_EXEC.
  - pc_op outside an exec_done cycle.
- next_pc by pc_op (`PC_OP_*` constants from AlicePU_const.vh):
  - NEXT_STEP: pc+4.
  - OFFSET_JMP: pc+4 + (offset_imm<<2), 32-bit modular.
  - IMM_JMP: {pc_plus4[31:28], inst[25:0], 2'b00}.
  - REG_JMP: reg_target.
  - Any other encoding: treated as NEXT_STEP.
- Arithmetic is 32-bit with wrap, no overflow flag; pc=32'hFFFF_FFFC with NEXT_STEP gives pc=0. retired_cnt wraps at 2^COUNT_W.
- pc changes only on a committed exec_done or on reset, so pc and pc_plus4 stay stable throughout S_EXEC for the jal link.
- Reset asserted mid-fetch: imem_req falls asynchronously and the fetch restarts from RESET_PC.

Optional Feature:
- Macro: PC_ALIGN_TRAP_EN.
- Defined:
  - If next_pc[1:0]!=0 at commit (only reachable via REG_JMP), enter an extra state S_TRAP. pc is not updated and retired_cnt still increments.
  - New outputs pc_trap (1 in S_TRAP) and trap_addr (32-bit, the offending next_pc).
  - imem_req=0; S_TRAP is left only by reset.
- Undefined: next_pc[1:0] is forced to 2'b00 and no trap ports exist.

Decomposition:
- Shared package/header AlicePU_const.vh additions:
  - FSM state encodings FETCH_S_BOOT, FETCH_S_FETCH, FETCH_S_EXEC, FETCH_S_TRAP, with FETCH_STATE_LEN.
  - Default reset PC constant.
- PC_OP_* constants are reused from AlicePU_const.vh.
- One natural sub-module: next_pc_calc, combinational (pc, pc_op, offset_imm, inst[25:0], reg_target -> next_pc, misaligned). It is instantiated once.

Test Plan:
- Reset, ack on the first S_FETCH cycle with rdata=32'h2008_0005, exec_done with NEXT_STEP -> imem_addr=32'h3000, inst=32'h2008_0005, then pc=32'h3004, retired_cnt=1.
- pc=32'h3010, OFFSET_JMP, offset_imm=32'hFFFF_FFFE -> pc=32'h300C. Same with offset_imm=3 -> pc=32'h3020.
- pc=32'h3000, inst=32'h0C00_0C10, IMM_JMP -> pc=32'h0000_3040; pc_plus4 reads 32'h3004 during S_EXEC.
- ack delayed 5 cycles with a spurious exec_done pulse during S_FETCH -> imem_req stays high for 6 cycles, addr stable, pc and count unchanged.
- pc=32'hFFFF_FFFC, NEXT_STEP -> pc=0. Reset asserted mid-S_FETCH -> imem_req=0 immediately, next fetch addr=RESET_PC.
- With PC_ALIGN_TRAP_EN, REG_JMP with reg_target=32'h3002 -> pc_trap=1, trap_addr=32'h3002, imem_req stays 0. Without the macro -> pc=32'h3000.
